regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 88 ++++++++
 rtl/regfile_sb.sv | 59 +++++
 tb/tb_regfile_sb.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the regfile_sb register file and its scoreboard.
// Optional write-through forwarding is selected by the REGFILE_BYPASS_EN macro.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int REG_ZERO   = 0;
  localparam int POP_MAX_W  = 256;

  // Busy vectors are zero-extended to POP_MAX_W bits before calling.
  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int n = 0;
    for (int i = 0; i < POP_MAX_W; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Operand-read / writeback / issue bus between the core pipeline and regfile_sb.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wen;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;
  logic                     busy_any;

  modport master (
    output rd_addr, wen, waddr, wdata, issue_en, issue_addr, flush,
    input  rd_data, rd_busy, busy_cnt, busy_any
  );

  modport slave (
    input  rd_addr, wen, waddr, wdata, issue_en, issue_addr, flush,
    output rd_data, rd_busy, busy_cnt, busy_any
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: busy vector, set/clear/flush priority and busy count.
// With REGFILE_BYPASS_EN, a same-cycle writeback hides the busy flag on matching read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_issue_en,
  input  logic [ADDR_W-1:0]        i_issue_addr,
  input  logic                     i_wen,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic                     i_flush,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_busy,
  output logic [ADDR_W:0]          o_busy_cnt,
  output logic                     o_busy_any
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_cnt_nxt;
  logic             w_set;
  logic             w_clr;
  logic             w_inc;
  logic             w_dec;
  logic [ADDR_W-1:0] w_idx;

  always_comb begin
    w_set      = i_issue_en && (i_issue_addr != ADDR_W'(REG_ZERO));
    // A new producer for the same register keeps it pending.
    w_clr      = i_wen && !(w_set && (i_issue_addr == i_waddr));
    w_busy_nxt = r_busy;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_clr) begin
        w_dec               = r_busy[i_waddr];
        w_busy_nxt[i_waddr] = 1'b0;
      end
      if (w_set) begin
        w_inc                    = !r_busy[i_issue_addr];
        w_busy_nxt[i_issue_addr] = 1'b1;
      end
    end
    w_cnt_nxt = i_flush ? '0
                        : r_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    o_rd_busy = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_idx = i_rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      o_rd_busy[i] = r_busy[w_idx] &&
                     !(i_wen && (i_waddr == w_idx) && (w_idx != ADDR_W'(REG_ZERO)) &&
                       !(i_issue_en && (i_issue_addr == w_idx)));
`else
      o_rd_busy[i] = r_busy[w_idx];
`endif
    end
  end

  assign o_busy_cnt = r_cnt;
  assign o_busy_any = (r_cnt != '0);

  cnt_matches_popcount: assert property (
    @(posedge clk) disable iff (rst)
    int'(r_cnt) == popcount(POP_MAX_W'(r_busy))
  );
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-pending scoreboard; x0 reads as zero.
// REGFILE_BYPASS_EN enables same-cycle write-through forwarding on every read port.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0]        r_mem [NREGS];
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0]        w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_mem[r] <= '0;
    end else if (bus.wen && (bus.waddr != ADDR_W'(REG_ZERO))) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_idx = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (w_idx != ADDR_W'(REG_ZERO)) w_rd_data[i*DATA_W +: DATA_W] = r_mem[w_idx];
`ifdef REGFILE_BYPASS_EN
      if (bus.wen && (bus.waddr == w_idx) && (w_idx != ADDR_W'(REG_ZERO)))
        w_rd_data[i*DATA_W +: DATA_W] = bus.wdata;
`endif
    end
  end

  assign bus.rd_data = w_rd_data;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_issue_en   (bus.issue_en),
    .i_issue_addr (bus.issue_addr),
    .i_wen        (bus.wen),
    .i_waddr      (bus.waddr),
    .i_flush      (bus.flush),
    .i_rd_addr    (bus.rd_addr),
    .o_rd_busy    (bus.rd_busy),
    .o_busy_cnt   (bus.busy_cnt),
    .o_busy_any   (bus.busy_any)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem  [NREGS];
  bit            m_busy [NREGS];

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += m_busy[r] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && int'(bus.waddr) == a) return bus.wdata;
`endif
    return m_mem[a];
  endfunction

  function automatic bit m_rbusy(input int a);
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && bus.wen && int'(bus.waddr) == a &&
        !(bus.issue_en && int'(bus.issue_addr) == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Apply the architectural rules for one clock edge using the driven inputs.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (bus.wen && bus.waddr != 0) m_mem[bus.waddr] = bus.wdata;
      if (bus.flush) begin
        for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      end else begin
        if (bus.wen) m_busy[bus.waddr] = 1'b0;
        if (bus.issue_en && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen        = 1'b0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.rd_addr = '0;
    tick();
    rst = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      bus.rd_addr = {AW'(NREGS-1-a), AW'(a)};
      #1;
      checks++;
      if (bus.rd_data[0 +: DW] !== '0 || bus.rd_data[DW +: DW] !== '0) begin
        errors++;
        $display("FAIL reset_rd_data x%0d got %h exp 0", a, bus.rd_data);
      end
      checks++;
      if (bus.rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_rd_busy x%0d got %b exp 00", a, bus.rd_busy);
      end
    end
    checks++;
    if (bus.busy_cnt !== 6'd0 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt got %0d any %b exp 0 0", bus.busy_cnt, bus.busy_any);
    end
  endtask

  task automatic test_write_read();
    idle();
    bus.wen = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    tick();
    idle();
    bus.rd_addr = {AW'(5), AW'(5)};
    #1;
    checks++;
    if (bus.rd_data[0 +: DW] !== 32'hDEADBEEF || bus.rd_data[DW +: DW] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_x5 got %h exp deadbeef on both", bus.rd_data);
    end
    bus.wen = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h1234;
    tick();
    idle();
    bus.rd_addr = {AW'(0), AW'(0)};
    #1;
    checks++;
    if (bus.rd_data !== '0) begin
      errors++;
      $display("FAIL write_x0 got %h exp 0", bus.rd_data);
    end
  endtask

  task automatic test_issue_wb();
    idle();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
    tick();
    idle();
    bus.rd_addr = {AW'(0), AW'(7)};
    #1;
    checks++;
    if (bus.rd_busy !== 2'b01 || bus.busy_cnt !== 6'd1 || bus.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL issue_x7 busy %b cnt %0d any %b exp 01 1 1", bus.rd_busy, bus.busy_cnt, bus.busy_any);
    end
    bus.wen = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h55;
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_busy !== 2'b00 || bus.busy_cnt !== 6'd0 || bus.busy_any !== 1'b0 ||
        bus.rd_data[0 +: DW] !== 32'h55) begin
      errors++;
      $display("FAIL wb_x7 busy %b cnt %0d data %h exp 00 0 55", bus.rd_busy, bus.busy_cnt, bus.rd_data[0 +: DW]);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
    bus.wen = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
    tick();
    idle();
    bus.rd_addr = {AW'(3), AW'(9)};
    #1;
    checks++;
    if (bus.rd_busy !== 2'b01 || bus.busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL issue_wb_same busy %b cnt %0d exp 01 1", bus.rd_busy, bus.busy_cnt);
    end
    bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
    bus.wen = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h999;
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_busy !== 2'b10 || bus.busy_cnt !== 6'd1 || bus.rd_data[0 +: DW] !== 32'h999) begin
      errors++;
      $display("FAIL issue3_wb9 busy %b cnt %0d data %h exp 10 1 999", bus.rd_busy, bus.busy_cnt, bus.rd_data[0 +: DW]);
    end
  endtask

  task automatic test_flush();
    for (int a = 1; a <= 3; a++) begin
      idle();
      bus.issue_en = 1'b1; bus.issue_addr = AW'(a);
      tick();
    end
    idle();
    #1;
    checks++;
    if (bus.busy_cnt !== 6'd3) begin
      errors++;
      $display("FAIL issue_123 cnt got %0d exp 3", bus.busy_cnt);
    end
    bus.flush = 1'b1;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
    bus.wen = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hF00D;
    tick();
    idle();
    bus.rd_addr = {AW'(12), AW'(4)};
    #1;
    checks++;
    if (bus.rd_busy !== 2'b00 || bus.busy_cnt !== 6'd0 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL flush busy %b cnt %0d any %b exp 00 0 0", bus.rd_busy, bus.busy_cnt, bus.busy_any);
    end
    checks++;
    if (bus.rd_data[DW +: DW] !== 32'hF00D) begin
      errors++;
      $display("FAIL flush_write got %h exp f00d", bus.rd_data[DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_b;
    idle();
    bus.wen = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'h1111;
    tick();
    idle();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd10;
    tick();
    idle();
    bus.wen = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'hCAFE;
    bus.rd_addr = {AW'(10), AW'(10)};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'hCAFE; exp_b = 2'b00;
`else
    exp_d = 32'h1111; exp_b = 2'b11;
`endif
    checks++;
    if (bus.rd_data[0 +: DW] !== exp_d || bus.rd_data[DW +: DW] !== exp_d || bus.rd_busy !== exp_b) begin
      errors++;
      $display("FAIL bypass_x10 data %h busy %b exp %h %b", bus.rd_data, bus.rd_busy, exp_d, exp_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_data[0 +: DW] !== 32'hCAFE || bus.rd_busy !== 2'b00 || bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL after_wb_x10 data %h busy %b cnt %0d exp cafe 00 0", bus.rd_data[0 +: DW], bus.rd_busy, bus.busy_cnt);
    end
  endtask

  task automatic test_random();
    int a [NR];
    for (int n = 0; n < 400; n++) begin
      bus.wen        = ($urandom_range(0, 1) == 1);
      bus.waddr      = AW'($urandom_range(0, NREGS-1));
      bus.wdata      = $urandom;
      bus.issue_en   = ($urandom_range(0, 2) != 0);
      bus.issue_addr = AW'($urandom_range(0, NREGS-1));
      bus.flush      = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NR; p++) begin
        a[p] = ($urandom_range(0, 3) == 0) ? int'(bus.waddr) : int'($urandom_range(0, NREGS-1));
      end
      bus.rd_addr = {AW'(a[1]), AW'(a[0])};
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (bus.rd_data[p*DW +: DW] !== m_read(a[p])) begin
          errors++;
          $display("FAIL rand_rd_data cyc %0d p%0d x%0d got %h exp %h", n, p, a[p], bus.rd_data[p*DW +: DW], m_read(a[p]));
        end
        checks++;
        if (bus.rd_busy[p] !== m_rbusy(a[p])) begin
          errors++;
          $display("FAIL rand_rd_busy cyc %0d p%0d x%0d got %b exp %b", n, p, a[p], bus.rd_busy[p], m_rbusy(a[p]));
        end
      end
      tick();
      checks++;
      if (int'(bus.busy_cnt) != m_count() || bus.busy_any !== (m_count() != 0)) begin
        errors++;
        $display("FAIL rand_cnt cyc %0d got %0d any %b exp %0d", n, bus.busy_cnt, bus.busy_any, m_count());
      end
    end
  endtask

  task automatic test_reset_pending();
    idle();
    for (int a = 1; a < 6; a++) begin
      bus.issue_en = 1'b1; bus.issue_addr = AW'(a * 5);
      bus.wen = 1'b1; bus.waddr = AW'(a * 3); bus.wdata = $urandom | 32'h1;
      tick();
    end
    rst = 1'b1;
    bus.wen = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'hABCD;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd8;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int a = 0; a < NREGS; a++) begin
      bus.rd_addr = {AW'(a), AW'(a)};
      #1;
      checks++;
      if (bus.rd_data !== '0 || bus.rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_pending x%0d data %h busy %b exp 0 00", a, bus.rd_data, bus.rd_busy);
      end
    end
    checks++;
    if (bus.busy_cnt !== 6'd0 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_cnt got %0d any %b exp 0 0", bus.busy_cnt, bus.busy_any);
    end
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    test_reset();
    test_write_read();
    test_issue_wb();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_random();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
